// File: rtl/fp_arith_pkg.sv
// Shared types and constants for the FP mantissa arithmetic datapath
// (used by both the Booth multiplier and the restoring divider).
package fp_arith_pkg;

  localparam int MANT_W = 24;
  localparam int QUO_W  = MANT_W + 2;

  typedef logic [MANT_W-1:0] mant_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: trial subtract of the divisor from the
// partial remainder, keeping the difference only when it is non-negative.
module divider_step #(
  parameter int MANT_W = 24
) (
  input  logic [MANT_W:0]   rem,
  input  logic [MANT_W-1:0] divisor,
  output logic              q_bit,
  output logic [MANT_W:0]   rem_next
);

  logic [MANT_W+1:0] diff;

  // One extra bit above the remainder acts as the borrow, so the sign of
  // the difference is the inverted quotient bit.
  always_comb begin
    diff     = {1'b0, rem} - {2'b00, divisor};
    q_bit    = ~diff[MANT_W+1];
    rem_next = q_bit ? diff[MANT_W:0] : rem;
  end

endmodule

// File: rtl/mantissa_divider_24bit.sv
// Sequential radix-2 restoring mantissa divider: one quotient bit per cycle,
// producing floor(A * 2^25 / B) plus a sticky bit for the rounding stage.
module mantissa_divider_24bit #(
  parameter int MANT_W = fp_arith_pkg::MANT_W,
  parameter int QUO_W  = MANT_W + 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [MANT_W-1:0] A_mantissa,
  input  logic [MANT_W-1:0] B_mantissa,
  output logic              ready,
  output logic              done,
  output logic [QUO_W-1:0]  quotient,
  output logic              sticky,
  output logic              div_by_zero
);

  import fp_arith_pkg::*;

  div_state_t        state, state_next;
  logic [MANT_W:0]   rem;
  logic [MANT_W-1:0] div_reg;
  logic [4:0]        count;
  logic              q_bit;
  logic [MANT_W:0]   rem_next;

  divider_step #(.MANT_W(MANT_W)) u_step (
    .rem      (rem),
    .divisor  (div_reg),
    .q_bit    (q_bit),
    .rem_next (rem_next)
  );

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = B_mantissa[MANT_W-1] ? RUN : DONE;
      RUN:  if (count == 5'd0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An unnormalized divisor skips RUN entirely and reports a saturated quotient.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rem         <= '0;
      div_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      sticky      <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            rem         <= {1'b0, A_mantissa};
            div_reg     <= B_mantissa;
            count       <= 5'(QUO_W - 1);
            sticky      <= 1'b0;
            quotient    <= B_mantissa[MANT_W-1] ? '0 : '1;
            div_by_zero <= ~B_mantissa[MANT_W-1];
          end
        end
        RUN: begin
          rem      <= rem_next << 1;
          quotient <= {quotient[QUO_W-2:0], q_bit};
          count    <= count - 5'd1;
          if (count == 5'd0) sticky <= |rem_next;
        end
        default: ;
      endcase
    end
  end

endmodule
